// File: rtl/pp_buf_pkg.sv
// Shared definitions for the ping-pong frame writer.
//   state_t     : frame writer FSM state encoding
//   GAP_CYC_DEF : default minimum number of Wr_en-low cycles between frames
//   CNT_W       : width of the status counters
//   CNT_MAX     : value at which the status counters stop counting
package pp_buf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        WRITE,
        CLOSE,
        GAP
    } state_t;

    localparam int GAP_CYC_DEF = 3;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/pp_frame_writer_sat_cnt16.sv
// 16-bit saturating event counter.
//   Wr_Clk : clock, rising edge
//   reset  : synchronous, active-high clear
//   inc    : count one event this cycle
//   cnt    : current count, sticks at CNT_MAX
module sat_cnt16
    import pp_buf_pkg::*;
(
    input  logic             Wr_Clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // NOTE: sequential state is assigned with <= so every register samples
    // its inputs from the same pre-edge values regardless of block order.
    always_ff @(posedge Wr_Clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pp_frame_writer.sv
// Frame writer feeding one half of a ping-pong sample buffer.
// On a trigger it waits for the buffer to be ready, writes frm_len samples
// (clamped to the buffer depth) at addresses 0..len-1 with Wr_en held high
// for the whole frame, reports the frame quality on Wr_frm_ok and enforces
// an idle gap before the next frame.
//   Wr_Clk     : sole clock, rising edge
//   reset      : synchronous, active-high
//   trig       : single-cycle capture request
//   abort      : terminate the current capture
//   frm_len    : samples per frame, taken when trig is accepted
//   s_data     : ADC sample
//   s_valid    : s_data qualifier
//   s_err      : sample error flag, qualified by s_valid
//   Wr_ready   : buffer can accept a new frame
//   Wr_en      : frame write enable
//   Wr_Addr    : write address
//   Wr_data    : write data
//   Wr_frm_ok  : frame-good flag, valid while Wr_en is low after a frame
//   busy       : high whenever the FSM is not in IDLE
//   frm_cnt    : good frames written
//   err_cnt    : frames closed with an error or abort
//   drop_cnt   : triggers ignored
module pp_frame_writer
    import pp_buf_pkg::*;
#(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 14,
    parameter int GAP_CYC       = GAP_CYC_DEF
) (
    input  logic                     Wr_Clk,
    input  logic                     reset,
    input  logic                     trig,
    input  logic                     abort,
    input  logic [RAM_ADDR_BITS:0]   frm_len,
    input  logic [RAM_WIDTH-1:0]     s_data,
    input  logic                     s_valid,
    input  logic                     s_err,
    input  logic                     Wr_ready,
    output logic                     Wr_en,
    output logic [RAM_ADDR_BITS-1:0] Wr_Addr,
    output logic [RAM_WIDTH-1:0]     Wr_data,
    output logic                     Wr_frm_ok,
    output logic                     busy,
    output logic [CNT_W-1:0]         frm_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam logic [RAM_ADDR_BITS:0] DEPTH = {1'b1, {RAM_ADDR_BITS{1'b0}}};
    localparam int                     GAP_W = $clog2(GAP_CYC);
    localparam logic [GAP_W-1:0]       GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_t                   state, state_d;
    logic [RAM_ADDR_BITS:0]   len_q, len_d;
    logic [RAM_ADDR_BITS:0]   ptr, ptr_d;
    logic                     ok_q, ok_d;
    logic [GAP_W-1:0]         gap_cnt, gap_d;
    logic                     wr_en_d;
    logic [RAM_ADDR_BITS-1:0] addr_d;
    logic [RAM_WIDTH-1:0]     data_d;
    logic                     frm_ok_d;
    logic                     busy_d;
    logic                     frm_inc, err_inc, drop_inc;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state;
        len_d    = len_q;
        ptr_d    = ptr;
        ok_d     = ok_q;
        gap_d    = gap_cnt;
        wr_en_d  = Wr_en;
        addr_d   = Wr_Addr;
        data_d   = Wr_data;
        frm_ok_d = Wr_frm_ok;
        frm_inc  = 1'b0;
        err_inc  = 1'b0;
        // A trigger is dropped when busy or when it asks for an empty frame.
        drop_inc = trig && ((state != IDLE) || (frm_len == '0));

        case (state)
            IDLE: begin
                if (trig && (frm_len != '0)) begin
                    len_d   = (frm_len > DEPTH) ? DEPTH : frm_len;
                    ok_d    = 1'b1;
                    ptr_d   = '0;
                    state_d = WAIT_RDY;
                end
            end

            WAIT_RDY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (Wr_ready) begin
                    state_d = WRITE;
                end
            end

            WRITE: begin
                if (abort) begin
                    // Nothing written yet: leave without producing a frame.
                    if (Wr_en) begin
                        ok_d    = 1'b0;
                        state_d = CLOSE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ptr == len_q) begin
                    // Frame complete; the last sample stays on the bus for
                    // the CLOSE cycle as well.
                    state_d = CLOSE;
                end else if (s_valid) begin
                    data_d  = s_data;
                    addr_d  = ptr[RAM_ADDR_BITS-1:0];
                    ptr_d   = ptr + (RAM_ADDR_BITS + 1)'(1);
                    wr_en_d = 1'b1;
                    if (s_err) begin
                        ok_d = 1'b0;
                    end
                end
            end

            CLOSE: begin
                wr_en_d  = 1'b0;
                frm_ok_d = ok_q;
                frm_inc  = ok_q;
                err_inc  = !ok_q;
                gap_d    = '0;
                state_d  = GAP;
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    frm_ok_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Wr_Clk) begin
        if (reset) begin
            state     <= IDLE;
            len_q     <= '0;
            ptr       <= '0;
            ok_q      <= 1'b0;
            gap_cnt   <= '0;
            Wr_en     <= 1'b0;
            Wr_Addr   <= '0;
            Wr_data   <= '0;
            Wr_frm_ok <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            len_q     <= len_d;
            ptr       <= ptr_d;
            ok_q      <= ok_d;
            gap_cnt   <= gap_d;
            Wr_en     <= wr_en_d;
            Wr_Addr   <= addr_d;
            Wr_data   <= data_d;
            Wr_frm_ok <= frm_ok_d;
            busy      <= busy_d;
        end
    end

    sat_cnt16 u_frm_cnt (
        .Wr_Clk (Wr_Clk),
        .reset  (reset),
        .inc    (frm_inc),
        .cnt    (frm_cnt)
    );

    sat_cnt16 u_err_cnt (
        .Wr_Clk (Wr_Clk),
        .reset  (reset),
        .inc    (err_inc),
        .cnt    (err_cnt)
    );

    sat_cnt16 u_drop_cnt (
        .Wr_Clk (Wr_Clk),
        .reset  (reset),
        .inc    (drop_inc),
        .cnt    (drop_cnt)
    );

endmodule
